audio_arbiter: RTL

Shares the single square-wave note generator between the background-music sequencer and up to three one-shot sound-effect sources. Effects pre-empt music, which resumes after a fixed silence gap. The block sits between the music sequencer / game-event logic and the audio note generator. It owns the generator's `note_en`/`note` inputs; no other block drives them.

---
 rtl/audio_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/audio_arbiter.sv
// Arbitrates the note generator between background music and three prioritised one-shot effects.
// Effects pre-empt music; a fixed silence gap follows every completed effect before music resumes.
module audio_arbiter #(
  parameter int unsigned FX_CYCLES  = 20_000_000,
  parameter int unsigned GAP_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bgm_en,
  input  logic        bgm_note_en,
  input  logic [3:0]  bgm_note,
  input  logic [2:0]  fx_req,
  input  logic [11:0] fx_note,
  input  logic        stop_all,
  output logic        note_en,
  output logic [3:0]  note,
  output logic [1:0]  grant,
  output logic [2:0]  fx_ack,
  output logic        fx_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BGM  = 2'd1,
    FX   = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [31:0] FX_LOAD  = 32'(FX_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

  state_t      state;
  state_t      nxt;
  logic [2:0]  pending;
  logic [1:0]  cur;
  logic [31:0] cnt;
  logic        stop_q;
  logic [1:0]  hi_idx;
  logic [1:0]  sel;
  logic        preempt;
  logic        enter_fx;
  logic        cnt_zero;

  always_comb begin
    hi_idx = 2'd0;
    if (pending[2])      hi_idx = 2'd2;
    else if (pending[1]) hi_idx = 2'd1;
  end

  assign preempt  = (pending[2] && (cur != 2'd2)) || (pending[1] && (cur == 2'd0));
  assign cnt_zero = (cnt == 32'd0);

  // stop_all is registered first, so the kill lands one edge after it is sampled.
  always_comb begin
    nxt      = state;
    enter_fx = 1'b0;
    if (stop_q) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            nxt      = FX;
            enter_fx = 1'b1;
          end else if (bgm_en) begin
            nxt = BGM;
          end
        end
        BGM: begin
          if (|pending) begin
            nxt      = FX;
            enter_fx = 1'b1;
          end else if (!bgm_en) begin
            nxt = IDLE;
          end
        end
        FX: begin
          if (preempt) begin
            nxt      = FX;
            enter_fx = 1'b1;
          end else if (cnt_zero) begin
            nxt = GAP;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            if (|pending) begin
              nxt      = FX;
              enter_fx = 1'b1;
            end else if (bgm_en) begin
              nxt = BGM;
            end else begin
              nxt = IDLE;
            end
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  assign sel = enter_fx ? hi_idx : cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 3'b000;
      cur     <= 2'd0;
      cnt     <= 32'd0;
      stop_q  <= 1'b0;
      note_en <= 1'b0;
      note    <= 4'd0;
      grant   <= 2'd0;
      fx_ack  <= 3'b000;
      fx_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nxt;
      stop_q  <= stop_all;
      fx_ack  <= 3'b000;
      fx_done <= 1'b0;
      busy    <= (nxt != IDLE);

      // A new request on the grant cycle re-sets the bit it would otherwise clear.
      if (stop_q)
        pending <= 3'b000;
      else if (enter_fx)
        pending <= (pending & ~(3'b001 << hi_idx)) | fx_req;
      else
        pending <= pending | fx_req;

      case (nxt)
        BGM: begin
          note_en <= bgm_note_en;
          note    <= bgm_note;
          grant   <= 2'd1;
        end
        FX: begin
          note_en <= 1'b1;
          note    <= fx_note[{sel, 2'b00} +: 4];
          grant   <= 2'd2;
        end
        default: begin
          note_en <= 1'b0;
          grant   <= 2'd0;
        end
      endcase

      if (stop_q) begin
        cnt <= 32'd0;
      end else if (enter_fx) begin
        cur    <= hi_idx;
        fx_ack <= 3'b001 << hi_idx;
        cnt    <= FX_LOAD;
      end else if (state == FX && nxt == GAP) begin
        fx_done <= 1'b1;
        cnt     <= GAP_LOAD;
      end else if ((state == FX || state == GAP) && !cnt_zero) begin
        cnt <= cnt - 32'd1;
      end
    end
  end

endmodule
